// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: write-back select codes and the hard-wired zero register.
package mips_defs;

   localparam int NREG_DEF = 32;
   localparam int DW_DEF   = 32;

   typedef logic [3:0] memtoreg_t;

   localparam memtoreg_t MEMTOREG_ALU = 4'd0;
   localparam memtoreg_t MEMTOREG_MEM = 4'd1;
   localparam memtoreg_t MEMTOREG_PC8 = 4'd2;
   localparam logic [4:0] REG_ZERO    = 5'd0;

   function automatic logic is_reg_zero(input logic [4:0] addr);
      return (addr == REG_ZERO);
   endfunction

endpackage

// File: rtl/wb_result_mux.sv
// W-stage result select: chooses the value committed to the register file.
// Unrecognised select codes fall back to the ALU result so the output is never X.
module wb_result_mux
   import mips_defs::*;
#(
   parameter int DW = 32
) (
   input  logic [3:0]    MemtoReg_W,
   input  logic [DW-1:0] ALUresult_W,
   input  logic [DW-1:0] MemOutput_W,
   input  logic [DW-1:0] PC8_W,
   output logic [DW-1:0] WD_W
);

   // select the write-back source
   always_comb begin
      WD_W = ALUresult_W;
      case (MemtoReg_W)
         MEMTOREG_ALU: WD_W = ALUresult_W;
         MEMTOREG_MEM: WD_W = MemOutput_W;
         MEMTOREG_PC8: WD_W = PC8_W;
         default:      WD_W = ALUresult_W;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file with same-cycle W->D bypass and a commit counter.
// Optional macro GRF_TRACE_EN prints one trace line per committed register write.
module wb_regfile
   import mips_defs::*;
#(
   parameter int NREG = 32,
   parameter int DW   = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    RegWrite_W,
   input  logic [3:0]              MemtoReg_W,
   input  logic [DW-1:0]           PC_W,
   input  logic [DW-1:0]           PC8_W,
   input  logic [DW-1:0]           ALUresult_W,
   input  logic [DW-1:0]           MemOutput_W,
   input  logic [$clog2(NREG)-1:0] Dst_W,
   input  logic [$clog2(NREG)-1:0] A1_D,
   input  logic [$clog2(NREG)-1:0] A2_D,
   output logic [DW-1:0]           RD1_D,
   output logic [DW-1:0]           RD2_D,
   output logic [DW-1:0]           WD_W,
   output logic [31:0]             wb_count
);

   localparam int AW = $clog2(NREG);

   logic [DW-1:0] regs_q [1:NREG-1];
   logic [DW-1:0] regs_d [1:NREG-1];
   logic [31:0]   wb_count_q;
   logic [31:0]   wb_count_d;
   logic          commit_s;

   wb_result_mux #(.DW(DW)) u_result_mux (
      .MemtoReg_W  (MemtoReg_W),
      .ALUresult_W (ALUresult_W),
      .MemOutput_W (MemOutput_W),
      .PC8_W       (PC8_W),
      .WD_W        (WD_W)
   );

   assign commit_s = RegWrite_W && (Dst_W != REG_ZERO);

   // next-state for the register array and commit counter
   always_comb begin
      regs_d     = regs_q;
      wb_count_d = wb_count_q;
      if (commit_s) begin
         regs_d[Dst_W] = WD_W;
         wb_count_d    = wb_count_q + 32'd1;
      end else begin
         wb_count_d = wb_count_q;
      end
   end

   // storage flops; reset clears everything asynchronously, dropping any pending write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wb_count_q <= 32'd0;
      end else begin
         regs_q     <= regs_d;
         wb_count_q <= wb_count_d;
`ifdef GRF_TRACE_EN
         if (commit_s) begin
            $display("%d@%h: $%d <= %h", $time, PC_W, Dst_W, WD_W);
         end
`endif
      end
   end

   // read port 1: zero register, then W-stage bypass, then stored value; gated off in reset
   always_comb begin
      RD1_D = '0;
      if (!reset || is_reg_zero(A1_D)) begin
         RD1_D = '0;
      end else if (RegWrite_W && (Dst_W == A1_D)) begin
         RD1_D = WD_W;
      end else begin
         RD1_D = regs_q[A1_D];
      end
   end

   // read port 2: same priority as port 1
   always_comb begin
      RD2_D = '0;
      if (!reset || is_reg_zero(A2_D)) begin
         RD2_D = '0;
      end else if (RegWrite_W && (Dst_W == A2_D)) begin
         RD2_D = WD_W;
      end else begin
         RD2_D = regs_q[A2_D];
      end
   end

   assign wb_count = wb_count_q;

   // PC_W only feeds the trace; keep it referenced when tracing is compiled out
   logic unused_pc_s;
   assign unused_pc_s = ^{PC_W, AW[0]};

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, commit, $0, bypass, select and counter wrap.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite_W;
   logic [3:0]  MemtoReg_W;
   logic [31:0] PC_W, PC8_W, ALUresult_W, MemOutput_W;
   logic [4:0]  Dst_W, A1_D, A2_D;
   logic [31:0] RD1_D, RD2_D, WD_W, wb_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk         (clk),
      .reset       (reset),
      .RegWrite_W  (RegWrite_W),
      .MemtoReg_W  (MemtoReg_W),
      .PC_W        (PC_W),
      .PC8_W       (PC8_W),
      .ALUresult_W (ALUresult_W),
      .MemOutput_W (MemOutput_W),
      .Dst_W       (Dst_W),
      .A1_D        (A1_D),
      .A2_D        (A2_D),
      .RD1_D       (RD1_D),
      .RD2_D       (RD2_D),
      .WD_W        (WD_W),
      .wb_count    (wb_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance past one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [3:0] sel, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc8);
      RegWrite_W  = we;
      MemtoReg_W  = sel;
      Dst_W       = dst;
      ALUresult_W = alu;
      MemOutput_W = mem;
      PC8_W       = pc8;
      PC_W        = pc8 - 32'd8;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      A1_D = 5'd0;
      A2_D = 5'd0;
      #12;
      check_eq("reset_count", wb_count, 32'd0);
      A1_D = 5'd7;
      #1;
      check_eq("reset_rd1", RD1_D, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // T2 write/read with bypass visible before the edge
      @(negedge clk);
      drive(1'b1, 4'd0, 5'd8, 32'hDEADBEEF, 32'h0, 32'h1008);
      A1_D = 5'd8;
      #1;
      check_eq("t2_bypass", RD1_D, 32'hDEADBEEF);
      check_eq("t2_wd", WD_W, 32'hDEADBEEF);
      tick();
      drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      #1;
      check_eq("t2_read", RD1_D, 32'hDEADBEEF);
      check_eq("t2_count", wb_count, 32'd1);

      // T1 write $5, then reset between edges with a write to $6 pending
      @(negedge clk);
      drive(1'b1, 4'd1, 5'd5, 32'h0, 32'h1234, 32'h1010);
      tick();
      drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      A1_D = 5'd5;
      #1;
      check_eq("t1_pre", RD1_D, 32'h1234);
      check_eq("t1_precount", wb_count, 32'd2);
      @(negedge clk);
      drive(1'b1, 4'd0, 5'd6, 32'h77, 32'h0, 32'h1018);
      #2;
      reset = 1'b0;
      #1;
      check_eq("t1_rd1_now", RD1_D, 32'd0);
      check_eq("t1_count_now", wb_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      A2_D = 5'd6;
      #1;
      check_eq("t1_after5", RD1_D, 32'd0);
      check_eq("t1_drop6", RD2_D, 32'd0);

      // T3 write to $0 is ignored
      @(negedge clk);
      drive(1'b1, 4'd1, 5'd0, 32'h0, 32'hFFFFFFFF, 32'h1020);
      A1_D = 5'd0;
      #1;
      check_eq("t3_wd", WD_W, 32'hFFFFFFFF);
      check_eq("t3_rd_before", RD1_D, 32'd0);
      tick();
      check_eq("t3_rd_after", RD1_D, 32'd0);
      check_eq("t3_count", wb_count, 32'd0);

      // T4 bypass both ports onto a register holding an older value
      @(negedge clk);
      drive(1'b1, 4'd0, 5'd9, 32'h11, 32'h0, 32'h1028);
      tick();
      drive(1'b1, 4'd2, 5'd9, 32'h55, 32'h66, 32'h3008);
      A1_D = 5'd9;
      A2_D = 5'd9;
      #1;
      check_eq("t4_rd1_byp", RD1_D, 32'h3008);
      check_eq("t4_rd2_byp", RD2_D, 32'h3008);
      tick();
      drive(1'b0, 4'd2, 5'd9, 32'h55, 32'h66, 32'h4008);
      #1;
      check_eq("t4_rd1_after", RD1_D, 32'h3008);
      check_eq("t4_rd2_after", RD2_D, 32'h3008);
      check_eq("t4_count", wb_count, 32'd2);

      // T5 unknown select falls back to ALU; disabled write leaves $3 alone
      @(negedge clk);
      drive(1'b0, 4'd7, 5'd3, 32'hA5, 32'h5A, 32'h5008);
      A1_D = 5'd3;
      A2_D = 5'd8;
      #1;
      check_eq("t5_wd", WD_W, 32'hA5);
      check_eq("t5_nobypass", RD1_D, 32'd0);
      tick();
      check_eq("t5_reg3", RD1_D, 32'd0);
      check_eq("t5_count", wb_count, 32'd2);

      // T6 counter wrap on a commit
      @(negedge clk);
      force dut.wb_count_q = 32'hFFFFFFFF;
      #1;
      release dut.wb_count_q;
      drive(1'b1, 4'd7, 5'd3, 32'hA5, 32'h5A, 32'h6008);
      #1;
      check_eq("t6_preset", wb_count, 32'hFFFFFFFF);
      tick();
      drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      #1;
      check_eq("t6_wrap", wb_count, 32'd0);
      check_eq("t6_reg3", RD1_D, 32'hA5);
      check_eq("t6_reg8_lost", RD2_D, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
